// File: rtl/titan_clint.sv
// Core-local interruptor: msip, 64-bit mtime with prescaler and mtimecmp behind a Wishbone classic slave.
// Registered ack/err one cycle after a request (at most one per two cycles); mtip lags mtime/mtimecmp by one cycle.

module titan_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTCMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTCMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;
    localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] presc_q,    presc_d;
    logic        msip_q,     msip_d;
    logic        ack_q,      ack_d;
    logic        err_q,      err_d;
    logic [31:0] dat_q,      dat_d;
    logic        mtip_q;

    logic [15:0] off;
    logic        base_hit;
    logic        req;
    logic        mapped;
    logic        wr_en;
    logic        tick;
    logic [31:0] rdata;
    logic        unused_addr_lsb;

    // Byte lane bits [1:0] carry no meaning on a word-only register file.
    assign unused_addr_lsb = ^wbs_addr_i[1:0];

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign off      = {wbs_addr_i[15:2], 2'b00};
    assign base_hit = (wbs_addr_i[31:16] == BASE_ADDR[31:16]);
    assign req      = wbs_cyc_i & wbs_stb_i & base_hit & ~ack_q & ~err_q;
    assign mapped   = (off == OFF_MSIP)     || (off == OFF_MTCMP_LO) ||
                      (off == OFF_MTCMP_HI) || (off == OFF_MTIME_LO) ||
                      (off == OFF_MTIME_HI);
    assign wr_en    = req & wbs_we_i & mapped;
    assign tick     = (presc_q == TICK_LAST);

    always_comb begin
        rdata = 32'h0;
        case (off)
            OFF_MSIP:     rdata = {31'h0, msip_q};
            OFF_MTCMP_LO: rdata = mtimecmp_q[31:0];
            OFF_MTCMP_HI: rdata = mtimecmp_q[63:32];
            OFF_MTIME_LO: rdata = mtime_q[31:0];
            OFF_MTIME_HI: rdata = mtime_q[63:32];
            default:      rdata = 32'h0;
        endcase
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        presc_d    = tick ? 16'h0 : presc_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

        // A software write to either mtime half overrides the increment and its carry.
        if (wr_en) begin
            case (off)
                OFF_MSIP: begin
                    if (wbs_sel_i[0]) begin
                        msip_d = wbs_dat_i[0];
                    end
                end
                OFF_MTCMP_LO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  wbs_dat_i, wbs_sel_i);
                OFF_MTCMP_HI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wbs_dat_i, wbs_sel_i);
                OFF_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], wbs_dat_i, wbs_sel_i)};
                    presc_d = 16'h0;
                end
                OFF_MTIME_HI: begin
                    mtime_d = {byte_merge(mtime_q[63:32], wbs_dat_i, wbs_sel_i), mtime_q[31:0]};
                    presc_d = 16'h0;
                end
                default: ;
            endcase
        end

        ack_d = req & mapped;
        err_d = req & ~mapped;
        dat_d = (req & mapped & ~wbs_we_i) ? rdata : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q    <= 16'h0;
            msip_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= 32'h0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            msip_q     <= msip_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            mtip_q     <= (mtime_q >= mtimecmp_q);
        end
    end

    assign wbs_dat_o   = dat_q;
    assign wbs_ack_o   = ack_q;
    assign wbs_err_o   = err_q;
    assign xint_mtip_o = mtip_q;
    assign xint_msip_o = msip_q;

endmodule

// File: tb/tb_titan_clint.sv
// Bench for titan_clint: two instances (TICK_DIV 1 and 3) on one shared bus, distinguished by base address.
// mtime is modelled as anchor value + elapsed edges / TICK_DIV, re-anchored on reset and on software writes.

module tb_titan_clint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'h0, wdat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat0, dat1;
    logic        ack0, ack1, err0, err1, mtip0, mtip1, msip0, msip1;

    int n_chk = 0;
    int n_err = 0;
    int edges = 0;

    longint unsigned a_val[2];
    longint unsigned cmp_m[2];
    int              a_edge[2];
    bit              msip_m[2];
    int              td[2];

    titan_clint #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(1)) u_clint0 (
        .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_o(dat0),
        .wbs_ack_o(ack0), .wbs_err_o(err0), .xint_mtip_o(mtip0), .xint_msip_o(msip0));

    titan_clint #(.BASE_ADDR(32'h0300_0000), .TICK_DIV(3)) u_clint1 (
        .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_o(dat1),
        .wbs_ack_o(ack1), .wbs_err_o(err1), .xint_mtip_o(mtip1), .xint_msip_o(msip1));

    initial forever #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_mapped(input logic [15:0] off);
        return off == 16'h0000 || off == 16'h4000 || off == 16'h4004 ||
               off == 16'hBFF8 || off == 16'hBFFC;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    // mtime value held after posedge number n
    function automatic longint unsigned mt(input int d, input int n);
        int steps;
        steps = (n - a_edge[d]) / td[d];
        return a_val[d] + 64'(steps);
    endfunction

    function automatic logic [31:0] reg_model(input int d, input logic [15:0] off, input int n);
        longint unsigned t;
        t = mt(d, n);
        case (off)
            16'h0000: return {31'h0, msip_m[d]};
            16'h4000: return cmp_m[d][31:0];
            16'h4004: return cmp_m[d][63:32];
            16'hBFF8: return t[31:0];
            16'hBFFC: return t[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            a_val[d]  = 64'h0;
            a_edge[d] = edges;
            cmp_m[d]  = 64'hFFFF_FFFF_FFFF_FFFF;
            msip_m[d] = 1'b0;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "/ctl"}, {ack0, err0, ack1, err1, mtip0, mtip1, msip0, msip1}, 64'h0);
        chk({tag, "/dat"}, {dat0, dat1}, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        reset_model();
    endtask

    // d=0/1 addresses an instance, d=2 an unclaimed base. Returns sampled termination.
    task automatic bus(input int d, input logic [15:0] off, input logic w, input logic [31:0] wd,
                       input logic [3:0] s, output logic [31:0] rd, output logic a,
                       output logic e, output int n);
        logic [31:0] base;
        base = (d == 0) ? 32'h0200_0000 : (d == 1) ? 32'h0300_0000 : 32'h0400_0000;
        @(negedge clk);
        n    = edges;
        cyc  = 1'b1; stb = 1'b1; we = w; wdat = wd; sel = s;
        addr = base | {16'h0, off} | 32'($urandom_range(0, 3));
        @(posedge clk);
        @(negedge clk);
        case (d)
            0:       begin rd = dat0; a = ack0; e = err0; end
            1:       begin rd = dat1; a = ack1; e = err1; end
            default: begin rd = dat0 | dat1; a = ack0 | ack1; e = err0 | err1; end
        endcase
        if (d == 0) chk("other_silent", {ack1, err1}, 64'h0);
        if (d == 1) chk("other_silent", {ack0, err0}, 64'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_op(input int d, input logic [15:0] off, input string tag,
                         output logic [31:0] rd);
        logic a, e;
        int   n;
        bus(d, off, 1'b0, 32'h0, 4'h0, rd, a, e, n);
        if (d == 2) begin
            chk({tag, "/silent"}, {a, e}, 64'h0);
        end else if (is_mapped(off)) begin
            chk({tag, "/ack"}, {a, e}, 64'h2);
            chk({tag, "/dat"}, rd, reg_model(d, off, n));
        end else begin
            chk({tag, "/err"}, {a, e}, 64'h1);
            chk({tag, "/dat0"}, rd, 64'h0);
        end
    endtask

    task automatic wr_op(input int d, input logic [15:0] off, input logic [31:0] wd,
                         input logic [3:0] s, input string tag);
        logic [31:0]     rd;
        logic            a, e;
        int              n;
        longint unsigned old;
        bus(d, off, 1'b1, wd, s, rd, a, e, n);
        if (d == 2) begin
            chk({tag, "/silent"}, {a, e}, 64'h0);
        end else if (!is_mapped(off)) begin
            chk({tag, "/err"}, {a, e}, 64'h1);
        end else begin
            chk({tag, "/ack"}, {a, e}, 64'h2);
            old = mt(d, n);
            case (off)
                16'h0000: begin
                    if (s[0]) msip_m[d] = wd[0];
                    chk({tag, "/msip"}, (d == 1) ? msip1 : msip0, msip_m[d]);
                end
                16'h4000: begin
                    old = cmp_m[d];
                    cmp_m[d] = {old[63:32], byte_merge(old[31:0], wd, s)};
                end
                16'h4004: begin
                    old = cmp_m[d];
                    cmp_m[d] = {byte_merge(old[63:32], wd, s), old[31:0]};
                end
                16'hBFF8: begin
                    a_val[d]  = {old[63:32], byte_merge(old[31:0], wd, s)};
                    a_edge[d] = n + 1;
                end
                16'hBFFC: begin
                    a_val[d]  = {byte_merge(old[63:32], wd, s), old[31:0]};
                    a_edge[d] = n + 1;
                end
                default: ;
            endcase
        end
    endtask

    // One idle cycle: mtip follows previous-cycle mtime/mtimecmp, bus outputs quiet.
    task automatic chk_idle();
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("mtip%0d", d), (d == 1) ? mtip1 : mtip0, 64'(mt(d, edges - 1) >= cmp_m[d]));
        chk("idle_term", {ack0, err0, ack1, err1}, 64'h0);
        chk("idle_dat", {dat0, dat1}, 64'h0);
    endtask

    initial begin
        logic [31:0] rd;
        td[0] = 1;
        td[1] = 3;

        do_reset();

        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            rd_op(1, 16'hBFF8, "tick", rd);
            chk("tick_val", rd, 64'(i));
            chk("tick_mtip", mtip1, 64'h0);
        end

        wr_op(0, 16'h4000, 32'hAABB_CCDD, 4'b0101, "be_wr");
        rd_op(0, 16'h4000, "be_rd", rd);
        chk("be_val", rd, 64'hFFBB_FFDD);

        wr_op(0, 16'h4004, 32'h0, 4'hF, "cmp_hi");
        wr_op(0, 16'hBFF8, 32'h0, 4'hF, "mt_lo0");
        wr_op(0, 16'h4000, 32'd10, 4'hF, "cmp_lo");
        repeat (14) chk_idle();
        chk("mtip_rise", mtip0, 64'h1);
        wr_op(0, 16'h4000, 32'hFFFF_FFFF, 4'hF, "cmp_lo_max");
        chk("mtip_hold", mtip0, 64'h1);
        @(negedge clk);
        chk("mtip_fall", mtip0, 64'h0);

        wr_op(1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, "carry_lo");
        wr_op(1, 16'hBFFC, 32'h0, 4'hF, "carry_hi");
        repeat (3) @(negedge clk);
        rd_op(1, 16'hBFF8, "carry_rd_lo", rd);
        chk("carry_lo_val", rd, 64'h0);
        rd_op(1, 16'hBFFC, "carry_rd_hi", rd);
        chk("carry_hi_val", rd, 64'h1);

        wr_op(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, "prio_lo");
        wr_op(0, 16'hBFFC, 32'd5, 4'hF, "prio_hi");
        rd_op(0, 16'hBFF8, "prio_rd_lo", rd);
        chk("prio_lo_val", rd, 64'h0);
        rd_op(0, 16'hBFFC, "prio_rd_hi", rd);
        chk("prio_hi_val", rd, 64'd6);
        wr_op(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, "prio2_lo");
        wr_op(0, 16'hBFF8, 32'h10, 4'hF, "prio2_lo_ovr");
        rd_op(0, 16'hBFFC, "prio2_rd_hi", rd);
        chk("prio2_hi_val", rd, 64'd6);

        wr_op(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, "wrap_hi");
        wr_op(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, "wrap_lo");
        rd_op(0, 16'hBFFC, "wrap_rd_hi", rd);
        rd_op(0, 16'hBFF8, "wrap_rd_lo", rd);
        chk("wrap_lo_val", rd, 64'h1);
        rd_op(0, 16'hBFFC, "wrap_rd_hi2", rd);
        chk("wrap_hi_val", rd, 64'h0);

        rd_op(0, 16'h0008, "dec_rd", rd);
        wr_op(0, 16'h0008, 32'hFFFF_FFFF, 4'hF, "dec_wr");
        rd_op(0, 16'h0000, "dec_msip", rd);
        rd_op(0, 16'h4000, "dec_cmp", rd);
        rd_op(2, 16'h4000, "nobase_rd", rd);
        wr_op(2, 16'h0000, 32'h1, 4'hF, "nobase_wr");
        chk("nobase_msip", {msip0, msip1}, 64'h0);
        chk_idle();

        wr_op(0, 16'h0000, 32'h1, 4'h1, "msip0_set");
        wr_op(1, 16'h0000, 32'hFFFF_FFFF, 4'hE, "msip1_nosel");
        wr_op(1, 16'h0000, 32'h1, 4'hF, "msip1_set");

        @(negedge clk);
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        addr = 32'h0200_4000; wdat = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst_req");
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk_reset_outs("rst_req2");
        rst = 1'b0;
        reset_model();
        rd_op(0, 16'h4000, "rst_cmp_lo", rd);
        chk("rst_cmp_val", rd, 64'hFFFF_FFFF);

        for (int i = 0; i < 200; i++) begin
            int          d;
            int          k;
            logic [15:0] off;
            d = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            k = int'($urandom_range(0, 5));
            case (k)
                0:       off = 16'h0000;
                1:       off = 16'h4000;
                2:       off = 16'h4004;
                3:       off = 16'hBFF8;
                4:       off = 16'hBFFC;
                default: begin
                    off = 16'($urandom) & 16'hFFFC;
                    if (is_mapped(off)) off = 16'h0010;
                end
            endcase
            if ($urandom_range(0, 1) == 1) wr_op(d, off, $urandom, 4'($urandom), "rnd_wr");
            else rd_op(d, off, "rnd_rd", rd);
            chk_idle();
        end

        do_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/titan_clint.md
TITAN_CLINT -- requirements
Module: titan_clint

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0200_0000, base of its 64 KB Wishbone window (only bits [31:16] are significant).
REQ-002 The block SHALL have parameter TICK_DIV, default 1, number of clk_i cycles per mtime increment (legal range 1..65535).
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port wbs_addr_i, input, 32, Wishbone byte address.
REQ-006 The block SHALL have port wbs_dat_i, input, 32, write data.
REQ-007 The block SHALL have port wbs_sel_i, input, 4, byte enables.
REQ-008 The block SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, each input, 1, with standard Wishbone classic meaning.
REQ-009 The block SHALL have port wbs_dat_o, output, 32, read data, valid while wbs_ack_o=1.
REQ-010 The block SHALL have ports wbs_ack_o and wbs_err_o, each output, 1, transfer termination.
REQ-011 The block SHALL have port xint_mtip_o, output, 1, machine timer interrupt pending, driving the core's xint_mtip_i.
REQ-012 The block SHALL have port xint_msip_o, output, 1, machine software interrupt pending, driving the core's xint_msip_i.

Function
REQ-013 The register map (offset = wbs_addr_i[15:2]<<2) SHALL be: 0x0000 msip (bit0 RW, bits[31:1] read 0); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-014 A request SHALL exist when wbs_cyc_i & wbs_stb_i & (wbs_addr_i[31:16]==BASE_ADDR[31:16]) & ~wbs_ack_o & ~wbs_err_o; wbs_addr_i[1:0] are ignored.
REQ-015 A request SHALL be terminated in the next cycle by exactly one single-cycle pulse: wbs_ack_o for a mapped offset, wbs_err_o for any other offset; no pulse appears in the next cycle, so a held stb gives one termination every 2 cycles.
REQ-016 A read SHALL register wbs_dat_o from the register value in the request cycle; wbs_dat_o SHALL be 0 when no ack is asserted.
REQ-017 A write SHALL update only the bytes whose wbs_sel_i bit is 1, taking effect on the clock edge that raises wbs_ack_o; an erroring write SHALL change no state.
REQ-018 A prescaler SHALL count 0..TICK_DIV-1 and wrap; mtime SHALL increment by 1 on each wrap; with TICK_DIV=1, mtime SHALL increment every cycle.
REQ-019 mtime SHALL be 64-bit, with the carry from [31:0] into [63:32] in the same cycle, and SHALL wrap from 2^64-1 to 0.
REQ-020 A write to either mtime half SHALL take priority over that cycle's increment: the written half takes the new bytes, and the other half is neither incremented nor receives a carry; the prescaler SHALL reset to 0 on any mtime write.
REQ-021 xint_mtip_o SHALL be registered as (mtime >= mtimecmp), unsigned 64-bit, using the post-update values, so it reflects a change one cycle after the edge that changed mtime or mtimecmp.
REQ-022 xint_msip_o SHALL equal msip bit0 directly, with no extra register.
REQ-023 If the bus master drops wbs_stb_i in the cycle the termination is asserted, the termination SHALL still complete and the write SHALL still take effect.

Reset
REQ-024 While rst_i=1 at a clock edge: mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, xint_mtip_o=0.
REQ-025 Reset asserted in the cycle of a request SHALL abort it: no termination and no register change.
REQ-026 mtime SHALL not increment in any cycle in which rst_i=1.

Verification
REQ-027 Tick: TICK_DIV=3, reset released -> mtime reads 0, 1, 2 at 3-cycle spacing; xint_mtip_o stays 0.
REQ-028 Compare: write mtimecmp_hi=0 then mtimecmp_lo=10 (TICK_DIV=1) -> xint_mtip_o rises exactly one cycle after mtime becomes 10; a later write of mtimecmp_lo=0xFFFF_FFFF -> xint_mtip_o falls one cycle after that write.
REQ-029 Carry/priority: write mtime_lo=0xFFFF_FFFF, mtime_hi=0 -> the next increment gives mtime_hi=1, mtime_lo=0; a write in the same cycle as a carry leaves the unwritten half unchanged.
REQ-030 Byte enables: write 0xAABBCCDD with sel=4'b0101 to mtimecmp_lo after reset -> readback 0xFFBBFFDD.
REQ-031 Decode: a read at offset 0x0008 -> wbs_err_o pulse only, with no ack and no state change; an access with addr[31:16]!=BASE_ADDR[31:16] -> no response.
REQ-032 msip/reset: write msip=1 -> xint_msip_o=1 the next cycle; assert rst_i during a write request to mtimecmp -> no ack, mtimecmp=all ones, and all outputs 0.
